mdu_hilo: RTL
=============

Name: mdu_hilo

Overview:
- Iterative multiply/divide unit for the pipelined MIPS core. Owns the HI and LO architectural registers.
- Sits in the EX stage.
- Its `hi`/`lo` outputs feed the EX result-select multiplexer, which is the source for MFHI/MFLO.
- Raises a stall toward the hazard unit while a 32-iteration operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clrn  in  1  reset, synchronous, active-low.
- start  in  1  EX-stage operation-valid pulse; sampled only in IDLE.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- a  in  32  rs operand (dividend / multiplicand / MT source).
- b  in  32  rt operand (divisor / multiplier).
- hilo_use  in  1  ID stage holds an MFHI/MFLO/MTHI/MTLO/MULT*/DIV* instruction.
- busy  out  1  state != IDLE.
- stall  out  1  busy & hilo_use.
- done  out  1  high for exactly the one cycle spent in FIN.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset: when clrn=0 at an edge, state=IDLE, count=0, hi=0, lo=0, internal accumulators=0. busy, stall and done are therefore 0 from the following cycle. Reset during CALC/FIN aborts the operation and leaves no partial result.
- States: IDLE, CALC, FIN.
- IDLE, start=1, op is MULT/MULTU/DIV/DIVU:
  - Latch operand magnitudes (absolute value for signed ops; raw value for unsigned).
  - Latch result-sign flags.
  - count=0, then go to CALC.
- IDLE, start=1, op=MTHI/MTLO: hi<=a or lo<=a at that edge; state stays IDLE; busy stays 0.
- IDLE, start=1, op=110/111: no effect.
- CALC: one iteration per edge; count increments. The edge where count==WIDTH-1 performs the last iteration and moves to FIN.
- Multiply iteration: shift-add. 64-bit product accumulator; add the multiplicand when the current multiplier bit is 1, then shift right.
- Divide iteration: restoring. Shift {rem,quot} left, trial-subtract the divisor, set the quotient bit on non-negative result.
- FIN: apply sign correction, write hi/lo at the edge, then go to IDLE.
- Sign correction for MULT: negate the 64-bit product iff a[31]^b[31]. hi=product[63:32], lo=product[31:0].
- Sign correction for DIV: negate the quotient iff a[31]^b[31]; the remainder takes the sign of a. lo=quotient, hi=remainder.
- Timing: start accepted at edge k. busy=1 from edge k through edge k+33 (33 cycles). done=1 between edges k+32 and k+33. New hi/lo are visible from edge k+33.
- Divide by zero (b==0), DIV or DIVU: lo=0xFFFFFFFF, hi=a (raw a, no sign fix); still 33 cycles.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Magnitude of 0x80000000 is handled as unsigned 0x80000000 (33-bit-safe negation).
- start while busy: ignored; the hazard unit guarantees it never occurs because stall holds ID.
- MTHI/MTLO while busy: ignored.
- hi/lo hold their values in CALC; there is no partial update.
- stall is combinational and is high in CALC and FIN whenever hilo_use=1.
- MFHI in ID during FIN stalls one more cycle, then reads the new value via the mux.

Test Plan:
- Reset: clrn=0 for 2 cycles, then 1 → hi=0, lo=0, busy=0, done=0.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 cycles: hi=0xFFFFFFFE, lo=0x00000001; done pulses exactly once, at cycle 33.
- MULT a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=7 → lo=14, hi=2.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Stall with MT: with hilo_use=1 during the op → stall=1 for all 33 busy cycles, 0 after. MTLO a=0xCAFEF00D while busy → lo unchanged. MTLO in IDLE → lo=0xCAFEF00D next cycle, busy stays 0.
- Reset mid-op: start DIVU, then clrn=0 at cycle 10 → busy=0, hi=lo=0, no done pulse. A following MULTU 3×4 → lo=12, hi=0.

Source files
------------

// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: EX-stage request/response bundle for the HI/LO multiply-divide unit.
//   start, op, a, b : operation request (rs/rt operands)
//   hilo_use        : ID stage holds a HI/LO-related instruction
//   busy, stall     : unit occupancy and hazard-unit stall
//   done            : one-cycle completion strobe
//   hi, lo          : architectural HI/LO registers
interface mdu_hilo_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hilo_use;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hilo_use,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hilo_use,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative shift-add multiplier / restoring divider owning HI and LO.
//   clk  : clock, all state changes on the rising edge
//   clrn : synchronous active-low reset
//   bus  : mdu_hilo_if slave (start/op/a/b/hilo_use in; busy/stall/done/hi/lo out)
// A MULT/DIV takes WIDTH CALC cycles plus one FIN cycle; MTHI/MTLO complete in IDLE.
module mdu_hilo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic  clk,
    input  logic  clrn,
    mdu_hilo_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned W2 = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [W2-1:0]    acc;       // product, or {remainder, quotient}
    logic [WIDTH-1:0] opnd;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0] raw_a;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;

    logic             is_mul_op;
    logic             is_div_op;
    logic             is_sgn_op;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_sub;
    logic [W2-1:0]    div_next;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    // Request decode and operand magnitudes; -0x80000000 wraps to 0x80000000, read as unsigned.
    always_comb begin
        is_mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
        is_div_op = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        is_sgn_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        mag_a     = (is_sgn_op && bus.a[WIDTH-1]) ? WIDTH'(-bus.a) : bus.a;
        mag_b     = (is_sgn_op && bus.b[WIDTH-1]) ? WIDTH'(-bus.b) : bus.b;
    end

    // One iteration of each algorithm, selected in CALC.
    always_comb begin
        mul_sum  = {1'b0, acc[W2-1:WIDTH]} + {1'b0, opnd};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[W2-1:1]};
        div_sh   = {acc[W2-1:WIDTH], acc[WIDTH-1]};
        div_sub  = div_sh[WIDTH-1:0] - opnd;
        div_next = (div_sh >= {1'b0, opnd}) ? {div_sub, acc[WIDTH-2:0], 1'b1}
                                            : {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    // Sign correction applied in FIN.
    always_comb begin
        prod_fix = neg_res ? W2'(-acc) : acc;
        quot_fix = neg_res ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? WIDTH'(-acc[W2-1:WIDTH]) : acc[W2-1:WIDTH];
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            raw_a    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (is_mul_op || is_div_op) begin
                            opnd     <= is_mul_op ? mag_a : mag_b;
                            acc      <= {{WIDTH{1'b0}}, (is_mul_op ? mag_b : mag_a)};
                            raw_a    <= bus.a;
                            is_div   <= is_div_op;
                            neg_res  <= is_sgn_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_rem  <= is_sgn_op && bus.a[WIDTH-1];
                            div_zero <= (bus.b == '0);
                            count    <= '0;
                            state    <= CALC;
                        end else if (bus.op == OP_MTHI) begin
                            hi_q <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            lo_q <= bus.a;
                        end
                    end
                end
                CALC: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    if (!is_div) begin
                        hi_q <= prod_fix[W2-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else if (div_zero) begin
                        hi_q <= raw_a;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == FIN);
    assign bus.stall = (state != IDLE) && bus.hilo_use;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule
